// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - K&S processor shared types
// Decoded-instruction encoding shared by the decoder, data_path and the control unit.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

endpackage

// File: rtl/ks_control_unit.sv
// rtl/ks_control_unit.sv - K&S multi-cycle control FSM
// Moore FSM driving data_path enables/selects, RAM write strobe and halt.
module ks_control_unit
  import k_and_s_pkg::*;
#(
  parameter int unsigned RAM_RD_LAT = 1,
  parameter bit          OV_SEL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_LOAD_WAIT, S_LOAD_WB, S_STORE,
    S_ALU, S_MOVE, S_BRANCH, S_HALT
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RAM_RD_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic       ovf;

  logic       br_s, pc_s, ir_s, as_s, cs_s, wr_s, fl_s, rw_s, h_s;
  logic [1:0] op_s;

  assign ovf = OV_SEL ? unsigned_overflow : signed_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    wait_d  = 3'd0;
    br_s = 1'b0; pc_s = 1'b0; ir_s = 1'b0; as_s = 1'b0; cs_s = 1'b0;
    wr_s = 1'b0; fl_s = 1'b0; rw_s = 1'b0; h_s  = 1'b0;
    op_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        as_s    = 1'b1;
        ir_s    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        as_s = 1'b1;
        pc_s = 1'b1;
        case (decoded_instruction)
          I_LOAD:                     state_d = S_LOAD_WAIT;
          I_STORE:                    state_d = S_STORE;
          I_ADD, I_SUB, I_AND, I_OR:  state_d = S_ALU;
          I_MOVE:                     state_d = S_MOVE;
          I_BRANCH:                   state_d = S_BRANCH;
          I_BZERO:                    state_d = zero_op  ? S_BRANCH : S_FETCH;
          I_BNZERO:                   state_d = !zero_op ? S_BRANCH : S_FETCH;
          I_BNEG:                     state_d = neg_op   ? S_BRANCH : S_FETCH;
          I_BNNEG:                    state_d = !neg_op  ? S_BRANCH : S_FETCH;
          I_BOV:                      state_d = ovf      ? S_BRANCH : S_FETCH;
          I_BNOV:                     state_d = !ovf     ? S_BRANCH : S_FETCH;
          I_HALT:                     state_d = S_HALT;
          default:                    state_d = S_FETCH;
        endcase
      end
      S_LOAD_WAIT: begin
        // RAM address is held on mem_addr while the read data settles
        if (wait_q == LAT_M1) begin
          state_d = S_LOAD_WB;
        end else begin
          wait_d  = wait_q + 3'd1;
          state_d = S_LOAD_WAIT;
        end
      end
      S_LOAD_WB: begin
        wr_s = 1'b1;
      end
      S_STORE: begin
        rw_s = 1'b1;
      end
      S_ALU: begin
        cs_s = 1'b1;
        wr_s = 1'b1;
        fl_s = 1'b1;
        case (decoded_instruction)
          I_ADD:   op_s = 2'b01;
          I_SUB:   op_s = 2'b10;
          I_AND:   op_s = 2'b11;
          default: op_s = 2'b00;
        endcase
      end
      S_MOVE: begin
        cs_s = 1'b1;
        wr_s = 1'b1;
      end
      S_BRANCH: begin
        pc_s = 1'b1;
        br_s = 1'b1;
      end
      S_HALT: begin
        h_s     = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Gate with rst_n so no strobe survives the falling reset edge.
  assign branch           = br_s & rst_n;
  assign pc_enable        = pc_s & rst_n;
  assign ir_enable        = ir_s & rst_n;
  assign addr_sel         = as_s & rst_n;
  assign c_sel            = cs_s & rst_n;
  assign operation        = op_s & {2{rst_n}};
  assign write_reg_enable = wr_s & rst_n;
  assign flags_reg_enable = fl_s & rst_n;
  assign ram_write_enable = rw_s & rst_n;
  assign halt             = h_s  & rst_n;

endmodule
